// File: rtl/mem_access_unit_pkg.sv
// rv_mem_pkg: funct3 codes, memory-unit state encoding and request legality check
package rv_mem_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  typedef enum logic [1:0] {MAU_IDLE = 2'd0, MAU_BUS = 2'd1, MAU_RESP = 2'd2} mau_state_e;
  function automatic logic req_legal(input logic write, input logic [2:0] f3, input logic [1:0] lo);
    logic f3_ok, aligned;
    f3_ok = write ? (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW)
                  : (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU);
    aligned = f3[1:0] == 2'b01 ? !lo[0] : f3[1:0] == 2'b10 ? lo == 2'b00 : 1'b1;
    return f3_ok && aligned;
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: datapath request/response and external word bus of the load/store unit
interface mem_access_unit_if;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, bus_ack, bus_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, bus_ack, bus_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: store byte-enable/lane replication and load extract with sign/zero extension
module mem_lane_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        write_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  logic [31:0] shifted;
  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    be_o    = !write_i ? 4'b1111
            : funct3_i[1:0] == 2'b00 ? 4'b0001 << addr_lo_i
            : funct3_i[1:0] == 2'b01 ? (addr_lo_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_o = funct3_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}}
            : funct3_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
    rdata_o = funct3_i == F3_LB  ? {{24{shifted[7]}}, shifted[7:0]}
            : funct3_i == F3_LH  ? {{16{shifted[15]}}, shifted[15:0]}
            : funct3_i == F3_LBU ? {24'd0, shifted[7:0]}
            : funct3_i == F3_LHU ? {16'd0, shifted[15:0]} : rdata_i;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store bridge from datapath memory port to a req/ack word bus.
// Define MAU_TIMEOUT_EN to abort bus cycles that see no ack within TIMEOUT_CYCLES.
module mem_access_unit
  import rv_mem_pkg::*;
`ifdef MAU_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 15
)
`endif
(
  input logic clk,
  input logic reset,
  mem_access_unit_if.slave mau
);
  mau_state_e  state_q, state_d;
  logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d, err_q, err_d, ok, tmo;
  logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d, rdata_q, rdata_d;
  logic [3:0]  bus_be_q, bus_be_d, be;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] wd, ld;
  // One aligner serves both directions: request fields in IDLE, latched fields while on the bus
  mem_lane_align u_align (
    .funct3_i  (state_q == MAU_IDLE ? mau.req_funct3 : f3_q),
    .addr_lo_i (state_q == MAU_IDLE ? mau.req_addr[1:0] : lo_q),
    .write_i   (state_q == MAU_IDLE ? mau.req_write : bus_we_q),
    .wdata_i   (mau.req_wdata),
    .rdata_i   (mau.bus_rdata),
    .be_o      (be),
    .wdata_o   (wd),
    .rdata_o   (ld)
  );
  assign ok = req_legal(mau.req_write, mau.req_funct3, mau.req_addr[1:0]);
`ifdef MAU_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  always_comb cnt_d = state_q == MAU_IDLE ? 4'd0 : (state_q == MAU_BUS && !mau.bus_ack) ? cnt_q + 4'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= !reset ? 4'd0 : cnt_d;
  assign tmo = state_q == MAU_BUS && !mau.bus_ack && cnt_q == 4'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) state_q <= !reset ? MAU_IDLE : state_d;
  always_comb begin
    state_d = state_q == MAU_IDLE ? (mau.req_valid ? (ok ? MAU_BUS : MAU_RESP) : MAU_IDLE)
            : state_q == MAU_BUS  ? ((mau.bus_ack || tmo) ? MAU_RESP : MAU_BUS)
            : MAU_IDLE;
  end
  always_comb begin
    mau.req_ready = state_q == MAU_IDLE;
    mau.rsp_valid = state_q == MAU_RESP;
    mau.rsp_err   = err_q;
    mau.rsp_rdata = rdata_q;
    mau.bus_req   = bus_req_q;
    mau.bus_we    = bus_we_q;
    mau.bus_addr  = bus_addr_q;
    mau.bus_be    = bus_be_q;
    mau.bus_wdata = bus_wdata_q;
  end
  always_comb begin
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    f3_d        = f3_q;
    lo_d        = lo_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    if (state_q == MAU_IDLE && mau.req_valid && ok) begin
      bus_req_d   = 1'b1;
      bus_we_d    = mau.req_write;
      bus_addr_d  = {mau.req_addr[31:2], 2'b00};
      bus_be_d    = be;
      bus_wdata_d = wd;
      f3_d        = mau.req_funct3;
      lo_d        = mau.req_addr[1:0];
    end
    if (state_q == MAU_IDLE && mau.req_valid && !ok) begin
      rdata_d = '0;
      err_d   = 1'b1;
    end
    if (state_q == MAU_BUS && (mau.bus_ack || tmo)) begin
      bus_req_d = 1'b0;
      rdata_d   = (mau.bus_ack && !bus_we_q) ? ld : '0;
      err_d     = !mau.bus_ack;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      f3_q        <= '0;
      lo_q        <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      f3_q        <= f3_d;
      lo_q        <= lo_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random accesses checked against an arithmetic reference model
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  mem_access_unit_if mif ();
  mem_access_unit dut (.clk(clk), .reset(reset), .mau(mif.slave));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic bit legal(input bit w, input int f3, input int off);
    if (f3 == 1 || f3 == 5) return (w ? f3 == 1 : 1'b1) && (off % 2 == 0);
    if (f3 == 2) return off == 0;
    if (f3 == 0) return 1'b1;
    if (f3 == 4) return !w;
    return 1'b0;
  endfunction
  function automatic int unsigned m_be(input bit w, input int f3, input int off);
    if (!w || f3 == 2) return 15;
    if (f3 == 0) return 1 << off;
    return off >= 2 ? 12 : 3;
  endfunction
  function automatic int unsigned m_wdata(input int f3, input int unsigned d);
    if (f3 == 0) return (d % 256) * 32'h01010101;
    if (f3 == 1) return (d % 65536) * 32'h00010001;
    return d;
  endfunction
  function automatic int unsigned m_load(input int f3, input int off, input int unsigned word);
    int unsigned s = word / (1 << (8 * off));
    int v;
    if (f3 == 2) return word;
    if (f3 == 0 || f3 == 4) begin
      v = int'(s % 256);
      return (f3 == 0 && v >= 128) ? 32'(v - 256) : 32'(v);
    end
    v = int'(s % 65536);
    return (f3 == 1 && v >= 32768) ? 32'(v - 65536) : 32'(v);
  endfunction
  // ack_at: bus_req cycle (1-based) in which the memory acks; 0 = never
  task automatic access(input bit w, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wd,
                        input bit [31:0] rd, input int ack_at, input bit junk);
    int off = int'(addr % 4);
    bit ok = legal(w, int'(f3), off);
    int reqc = 0;
    int k = 0;
    int exp_reqc;
    bit exp_err;
`ifdef MAU_TIMEOUT_EN
    exp_reqc = (ack_at == 0 || ack_at > 15) ? 15 : ack_at;
`else
    exp_reqc = ack_at;
`endif
    exp_err = !ok || exp_reqc != ack_at;
    chk("ready_idle", mif.req_ready, 1);
    mif.req_valid = 1; mif.req_write = w; mif.req_funct3 = f3; mif.req_addr = addr; mif.req_wdata = wd;
    step();
    mif.req_valid = 0;
    if (ok) begin
      while (!mif.rsp_valid && k < 60) begin
        if (mif.bus_req) begin
          reqc++;
          chk("bus_addr", mif.bus_addr, addr - addr % 4);
          chk("bus_we", mif.bus_we, w);
          chk("bus_be", mif.bus_be, m_be(w, int'(f3), off));
          if (w) chk("bus_wdata", mif.bus_wdata, m_wdata(int'(f3), wd));
        end
        chk("ready_busy", mif.req_ready, 0);
        if (junk) begin
          mif.req_valid = 1'($urandom_range(0, 1));
          mif.req_addr = $urandom; mif.req_funct3 = 3'($urandom); mif.req_write = 1'($urandom);
        end
        mif.bus_ack = reqc == ack_at;
        mif.bus_rdata = reqc == ack_at ? rd : $urandom;
        step();
        mif.bus_ack = 0; mif.req_valid = 0;
        k++;
      end
      chk("bus_req_cycles", reqc, exp_reqc);
    end
    chk("rsp_valid", mif.rsp_valid, 1);
    chk("latency", k + 2, ok ? exp_reqc + 2 : 2);
    chk("bus_req_in_resp", mif.bus_req, 0);
    chk("rsp_err", mif.rsp_err, exp_err);
    chk("rsp_rdata", mif.rsp_rdata, (exp_err || w) ? 0 : m_load(int'(f3), off, rd));
    step();
    chk("rsp_pulse", mif.rsp_valid, 0);
  endtask
  initial begin
    mif.req_valid = 0; mif.req_write = 0; mif.req_funct3 = 0; mif.req_addr = 0; mif.req_wdata = 0;
    mif.bus_ack = 0; mif.bus_rdata = 0;
    step(); step();
    chk("rst_ready", mif.req_ready, 1);
    chk("rst_bus_req", mif.bus_req, 0);
    chk("rst_bus_we", mif.bus_we, 0);
    chk("rst_bus_be", mif.bus_be, 0);
    chk("rst_bus_addr", mif.bus_addr, 0);
    chk("rst_bus_wdata", mif.bus_wdata, 0);
    chk("rst_rsp", {mif.rsp_valid, mif.rsp_err}, 0);
    chk("rst_rdata", mif.rsp_rdata, 0);
    reset = 1;
    step();
    access(1, 3'b010, 32'h0, 32'h18, 32'h0, 1, 0);
    access(0, 3'b000, 32'h3, 32'h0, 32'h80FF0000, 1, 0);
    access(0, 3'b100, 32'h3, 32'h0, 32'h80FF0000, 1, 0);
    access(1, 3'b001, 32'h6, 32'hABCD1234, 32'h0, 2, 0);
    access(0, 3'b001, 32'h5, 32'h0, 32'h0, 1, 0);
    access(0, 3'b010, 32'h10, 32'h0, 32'hCAFEF00D, 5, 1);
    access(1, 3'b100, 32'h8, 32'h55, 32'h0, 1, 0);
    access(0, 3'b011, 32'h0, 32'h0, 32'h0, 1, 0);
    // ack outside BUS must not produce a response
    mif.bus_ack = 1; mif.bus_rdata = 32'hFFFFFFFF;
    step();
    mif.bus_ack = 0;
    chk("stray_ack", {mif.rsp_valid, mif.bus_req}, 0);
    // reset while the bus cycle is outstanding
    mif.req_valid = 1; mif.req_write = 0; mif.req_funct3 = 3'b010; mif.req_addr = 32'h20;
    step();
    mif.req_valid = 0;
    step();
    chk("pre_rst_bus_req", mif.bus_req, 1);
    reset = 0;
    step();
    reset = 1;
    chk("mid_rst_bus_req", mif.bus_req, 0);
    chk("mid_rst_ready", mif.req_ready, 1);
    mif.bus_ack = 1; mif.bus_rdata = 32'h12345678;
    step();
    mif.bus_ack = 0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack_no_rsp", mif.rsp_valid, 0);
      step();
    end
    access(0, 3'b101, 32'h22, 32'h0, 32'h9ABC5678, 3, 0);
`ifdef MAU_TIMEOUT_EN
    access(0, 3'b010, 32'h40, 32'h0, 32'h1, 0, 0);
    access(0, 3'b010, 32'h44, 32'h0, 32'h2468ACE0, 15, 0);
`endif
    for (int i = 0; i < 40; i++)
      access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(1, 4)), 1'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
